// File: rtl/palindrome_serial_detector_if.sv
`default_nettype none
// ============================================================================
// Module      : palindrome_serial_detector_if
// Description : Bundles the serial input stream and the detector result
//               outputs of palindrome_serial_detector.
// Revision    : 1.0 - initial release
// ============================================================================
interface palindrome_serial_detector_if #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
);
    logic               in_valid;
    logic               in_bit;
    logic               clear;
    logic [WIDTH-1:0]   window;
    logic               full;
    logic               match;
    logic [COUNT_W-1:0] match_count;

    // Stream source side: drives bits, observes detector results
    modport master (
        output in_valid,
        output in_bit,
        output clear,
        input  window,
        input  full,
        input  match,
        input  match_count
    );

    // Detector side
    modport slave (
        input  in_valid,
        input  in_bit,
        input  clear,
        output window,
        output full,
        output match,
        output match_count
    );
endinterface
`default_nettype wire

// File: rtl/palindrome_serial_detector.sv
`default_nettype none
// ============================================================================
// Module      : palindrome_serial_detector
// Description : Sliding-window palindrome detector on a serial bit stream.
//               Keeps the last WIDTH accepted bits and pulses match for every
//               accepted bit after which the full window is a palindrome.
//               A saturating counter tallies matches since reset.
// Revision    : 1.0 - initial release
// ============================================================================
module palindrome_serial_detector #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
) (
    input  wire                          clk,
    input  wire                          rst,
    palindrome_serial_detector_if.slave  bus
);

    localparam int                 FILL_W      = $clog2(WIDTH + 1);
    localparam logic [FILL_W-1:0]  C_FILL_MAX  = FILL_W'(WIDTH);
    localparam logic [COUNT_W-1:0] C_COUNT_MAX = '1;

    logic [WIDTH-1:0]   r_window;
    logic [FILL_W-1:0]  r_fill;
    logic               r_match;
    logic [COUNT_W-1:0] r_count;

    logic               w_accept;
    logic [WIDTH-1:0]   w_window_next;
    logic [FILL_W-1:0]  w_fill_next;
    logic               w_palin;
    logic               w_match_next;

    // clear outranks in_valid, so a bit presented together with clear is lost
    assign w_accept      = bus.in_valid & ~bus.clear;
    assign w_window_next = {r_window[WIDTH-2:0], bus.in_bit};
    assign w_fill_next   = (r_fill == C_FILL_MAX) ? r_fill : r_fill + FILL_W'(1);

    // Mirror-compare the candidate window; an odd centre bit has no partner
    always_comb begin
        w_palin = 1'b1;
        for (int i = 0; i < WIDTH / 2; i++) begin
            if (w_window_next[i] != w_window_next[WIDTH-1-i]) begin
                w_palin = 1'b0;
            end
        end
    end

    // Fill gating keeps the zeroed post-flush window from counting as data
    assign w_match_next = w_accept & (w_fill_next == C_FILL_MAX) & w_palin;

    // Window, fill, match pulse and saturating match counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_window <= '0;
            r_fill   <= '0;
            r_match  <= 1'b0;
            r_count  <= '0;
        end else if (bus.clear) begin
            r_window <= '0;
            r_fill   <= '0;
            r_match  <= 1'b0;
        end else if (w_accept) begin
            r_window <= w_window_next;
            r_fill   <= w_fill_next;
            r_match  <= w_match_next;
            if (w_match_next && (r_count != C_COUNT_MAX)) begin
                r_count <= r_count + COUNT_W'(1);
            end
        end else begin
            r_match  <= 1'b0;
        end
    end

    assign bus.window      = r_window;
    assign bus.full        = (r_fill == C_FILL_MAX);
    assign bus.match       = r_match;
    assign bus.match_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_palindrome_serial_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_palindrome_serial_detector
// Description : Scoreboard bench for palindrome_serial_detector. Four DUTs of
//               different WIDTH/COUNT_W see the same stimulus; a reference
//               model per DUT predicts each cycle's outputs into a queue that
//               a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_palindrome_serial_detector;

    typedef struct {
        longint unsigned win;
        bit              full;
        bit              match;
        longint unsigned cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    palindrome_serial_detector_if #(.WIDTH(4), .COUNT_W(16)) if0 ();
    palindrome_serial_detector_if #(.WIDTH(4), .COUNT_W(3))  if1 ();
    palindrome_serial_detector_if #(.WIDTH(5), .COUNT_W(16)) if2 ();
    palindrome_serial_detector_if #(.WIDTH(2), .COUNT_W(1))  if3 ();

    palindrome_serial_detector #(.WIDTH(4), .COUNT_W(16)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    palindrome_serial_detector #(.WIDTH(4), .COUNT_W(3))  u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    palindrome_serial_detector #(.WIDTH(5), .COUNT_W(16)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
    palindrome_serial_detector #(.WIDTH(2), .COUNT_W(1))  u_dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

    // Reference model state: accepted-bit history and count since rst/clear
    longint unsigned m_hist [4];
    int              m_n    [4];
    longint unsigned m_cnt  [4];
    bit              m_match[4];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];

    int checks_total  = 0;
    int checks_passed = 0;

    function automatic longint unsigned mask_of(input int w);
        if (w >= 64) return '1;
        return (longint'(1) << w) - 1;
    endfunction

    function automatic longint unsigned reverse_bits(input longint unsigned x, input int w);
        longint unsigned r = 0;
        for (int i = 0; i < w; i++) r = (r << 1) | ((x >> i) & 1);
        return r;
    endfunction

    // Advance model k by one clock edge and queue its expected outputs
    function automatic void model_step(input int k, input int w, input int cw,
                                       input bit v, input bit b, input bit c, input bit r);
        exp_t            e;
        longint unsigned win;
        longint unsigned cmax = (longint'(1) << cw) - 1;
        if (r) begin
            m_hist[k] = 0; m_n[k] = 0; m_cnt[k] = 0; m_match[k] = 0;
        end else if (c) begin
            m_hist[k] = 0; m_n[k] = 0; m_match[k] = 0;
        end else if (v) begin
            m_hist[k] = (m_hist[k] << 1) | longint'(b);
            m_n[k]++;
            win = m_hist[k] & mask_of(w);
            m_match[k] = (m_n[k] >= w) && (win == reverse_bits(win, w));
            if (m_match[k] && m_cnt[k] < cmax) m_cnt[k]++;
        end else begin
            m_match[k] = 0;
        end
        e.win   = m_hist[k] & mask_of(w);
        e.full  = (m_n[k] >= w);
        e.match = m_match[k];
        e.cnt   = m_cnt[k];
        case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endfunction

    // Present one cycle of stimulus to every DUT and predict the result
    task automatic step(input bit v, input bit b, input bit c, input bit r);
        rst = r;
        if0.in_valid = v; if0.in_bit = b; if0.clear = c;
        if1.in_valid = v; if1.in_bit = b; if1.clear = c;
        if2.in_valid = v; if2.in_bit = b; if2.clear = c;
        if3.in_valid = v; if3.in_bit = b; if3.clear = c;
        @(posedge clk);
        model_step(0, 4, 16, v, b, c, r);
        model_step(1, 4, 3,  v, b, c, r);
        model_step(2, 5, 16, v, b, c, r);
        model_step(3, 2, 1,  v, b, c, r);
        #1;
    endtask

    task automatic stream(input bit [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks_total++;
        if (act == exp) checks_passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic cmp(input int k, input exp_t e, input longint unsigned win,
                       input bit full, input bit match, input longint unsigned cnt);
        chk($sformatf("dut%0d window", k),      win,   e.win);
        chk($sformatf("dut%0d full", k),        full,  e.full);
        chk($sformatf("dut%0d match", k),       match, e.match);
        chk($sformatf("dut%0d match_count", k), cnt,   e.cnt);
    endtask

    // Monitor: outputs are valid every cycle, so pop one prediction per negedge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                cmp(0, e, longint'(if0.window), if0.full, if0.match, longint'(if0.match_count));
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                cmp(1, e, longint'(if1.window), if1.full, if1.match, longint'(if1.match_count));
            end
            if (q2.size() > 0) begin
                e = q2.pop_front();
                cmp(2, e, longint'(if2.window), if2.full, if2.match, longint'(if2.match_count));
            end
            if (q3.size() > 0) begin
                e = q3.pop_front();
                cmp(3, e, longint'(if3.window), if3.full, if3.match, longint'(if3.match_count));
            end
        end
    end

    initial begin
        bit b_tog;
        for (int k = 0; k < 4; k++) begin
            m_hist[k] = 0; m_n[k] = 0; m_cnt[k] = 0; m_match[k] = 0;
        end

        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // 1,0,0,1,0,0,1
        stream(32'b1001001, 7);

        // All-zero stream: fill rule
        step(1'b0, 1'b0, 1'b0, 1'b1);
        stream(32'b00000, 5);

        // Gaps with toggling in_bit
        step(1'b0, 1'b0, 1'b0, 1'b1);
        stream(32'b11, 2);
        b_tog = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, b_tog, 1'b0, 1'b0);
            b_tog = ~b_tog;
        end
        stream(32'b11, 2);

        // Clear mid-stream drops the concurrent bit
        step(1'b0, 1'b0, 1'b0, 1'b1);
        stream(32'b100, 3);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        stream(32'b1001, 4);

        // Saturation, then rst mid-stream
        step(1'b0, 1'b0, 1'b0, 1'b1);
        stream(32'hFFF, 12);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        stream(32'b111, 3);

        // Odd width streams
        step(1'b0, 1'b0, 1'b0, 1'b1);
        stream(32'b10101, 5);
        stream(32'b11011, 5);

        // Randomised traffic with occasional clear and rst
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 80),
                 ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 50 : 90)),
                 ($urandom_range(0, 99) < 3),
                 ($urandom_range(0, 199) < 1));
        end

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard drained", longint'(q0.size() + q1.size() + q2.size() + q3.size()), 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
`default_nettype wire
